// File: rtl/updn_cmd_gen.sv
// Button front end for the 5-bit up/down counter: sync, debounce, press/auto-repeat
// pulse generation, Load > Down > Up arbitration and High/Low request gating.
module updn_cmd_gen #(
  parameter int WIDTH         = 5,
  parameter int DB_CYCLES     = 4,
  parameter int HOLD_DELAY    = 16,
  parameter int REPEAT_PERIOD = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             BTN_UP,
  input  logic             BTN_DN,
  input  logic             BTN_LD,
  input  logic [WIDTH-1:0] SW,
  input  logic             High,
  input  logic             Low,
  output logic             Up,
  output logic             Down,
  output logic             Load,
  output logic [WIDTH-1:0] IN
);

  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam int HP = (HOLD_DELAY > REPEAT_PERIOD) ? HOLD_DELAY : REPEAT_PERIOD;
  localparam int HW = $clog2(HP + 1);
  localparam logic [CW-1:0] DB_LAST   = CW'(DB_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_DELAY - 1);
  localparam logic [HW-1:0] REP_LOAD  = HW'(REPEAT_PERIOD - 1);

  // bit 0 = up, bit 1 = down, bit 2 = load
  logic [2:0]    btn_raw;
  logic [2:0]    sync1;
  logic [2:0]    sync2;
  logic [2:0]    db;
  logic [2:0]    db_prev;
  logic [2:0]    press;
  logic [CW-1:0] db_cnt [3];
  logic [HW-1:0] hold_cnt [2];
  logic [1:0]    rpt;
  logic          up_evt;
  logic          dn_evt;
  logic          ld_evt;

  assign btn_raw = {BTN_LD, BTN_DN, BTN_UP};

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync1   <= '0;
      sync2   <= '0;
      db      <= '0;
      db_prev <= '0;
      for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
    end else begin
      sync1   <= btn_raw;
      sync2   <= sync1;
      db_prev <= db;
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] != db[i]) begin
          if (db_cnt[i] == DB_LAST) begin
            db[i]     <= ~db[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + 1'b1;
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  assign press = db & ~db_prev;

  // Hold timer reaching zero marks a repeat slot; the press cycle itself is excluded.
  always_comb begin
    rpt = '0;
    for (int i = 0; i < 2; i++) begin
      rpt[i] = db[i] && !press[i] && (hold_cnt[i] == '0);
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < 2; i++) hold_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (!db[i])        hold_cnt[i] <= '0;
        else if (press[i]) hold_cnt[i] <= HOLD_LOAD;
        else if (rpt[i])   hold_cnt[i] <= REP_LOAD;
        else               hold_cnt[i] <= hold_cnt[i] - 1'b1;
      end
    end
  end

  assign up_evt = press[0] | rpt[0];
  assign dn_evt = press[1] | rpt[1];
  assign ld_evt = press[2];

  // A gated winner still owns the cycle, so the lower-priority event is lost.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      Up   <= 1'b0;
      Down <= 1'b0;
      Load <= 1'b0;
      IN   <= '0;
    end else begin
      Up   <= 1'b0;
      Down <= 1'b0;
      Load <= 1'b0;
      if (ld_evt) begin
        Load <= 1'b1;
        IN   <= SW;
      end else if (dn_evt) begin
        Down <= !Low;
      end else if (up_evt) begin
        Up <= !High;
      end
    end
  end

endmodule

// File: tb/tb_updn_cmd_gen.sv
// Directed bench for updn_cmd_gen: a history-window model checked every cycle,
// plus literal pulse-timing expectations for each scenario.
module tb_updn_cmd_gen;

  localparam int K_UP = 1;
  localparam int K_DN = 2;
  localparam int K_LD = 3;

  logic       CLK, RST;
  logic       BTN_UP, BTN_DN, BTN_LD;
  logic [4:0] SW;
  logic       High, Low;
  logic       Up, Down, Load;
  logic [4:0] IN;

  updn_cmd_gen dut (
    .CLK(CLK), .RST(RST), .BTN_UP(BTN_UP), .BTN_DN(BTN_DN), .BTN_LD(BTN_LD),
    .SW(SW), .High(High), .Low(Low), .Up(Up), .Down(Down), .Load(Load), .IN(IN)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {int c; int k;} ev_t;
  ev_t log_q[$];
  ev_t exp_q[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic want(input int c, input int k);
    ev_t e;
    e.c = c;
    e.k = k;
    exp_q.push_back(e);
  endtask

  task automatic check_log(input string name);
    chk({name, "_count"}, log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      chk({name, "_cyc"}, log_q[i].c, exp_q[i].c);
      chk({name, "_kind"}, log_q[i].k, exp_q[i].k);
    end
    log_q.delete();
    exp_q.delete();
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge CLK);
  endtask

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial forever begin
    @(posedge CLK);
    cyc++;
  end

  // Model: db flips once the last DB_CYCLES synchronised samples (raw delayed by
  // two edges) all disagree with it; repeats fall at age 16, 24, 32, ... after a press.
  bit [7:0] h [3];
  bit [2:0] dbm, dbpm, press_m, raw_m;
  bit [1:0] rep_m;
  int       age [2];
  logic     eu, ed, el;
  logic [4:0] ein;

  initial forever begin
    @(posedge CLK or negedge RST);
    if (!RST) begin
      for (int b = 0; b < 3; b++) h[b] = '0;
      dbm = '0; dbpm = '0;
      age[0] = 0; age[1] = 0;
      eu = 0; ed = 0; el = 0; ein = '0;
    end else begin
      raw_m   = {BTN_LD, BTN_DN, BTN_UP};
      press_m = dbm & ~dbpm;
      for (int b = 0; b < 2; b++)
        rep_m[b] = dbm[b] && !press_m[b] && age[b] >= 16 && ((age[b] - 16) % 8 == 0);
      eu = 0; ed = 0; el = 0;
      if (press_m[2]) begin
        el  = 1;
        ein = SW;
      end else if (press_m[1] || rep_m[1]) begin
        ed = !Low;
      end else if (press_m[0] || rep_m[0]) begin
        eu = !High;
      end
      for (int b = 0; b < 2; b++) begin
        if (press_m[b])  age[b] = 1;
        else if (dbm[b]) age[b] = age[b] + 1;
        else             age[b] = 0;
      end
      dbpm = dbm;
      for (int b = 0; b < 3; b++) begin
        h[b] = {h[b][6:0], raw_m[b]};
        if (h[b][5:2] == {4{~dbm[b]}}) dbm[b] = ~dbm[b];
      end
    end
  end

  initial forever begin
    @(negedge CLK);
    if (cyc > 0) begin
      chk("model_up",   int'(Up),   int'(eu));
      chk("model_down", int'(Down), int'(ed));
      chk("model_load", int'(Load), int'(el));
      chk("model_in",   int'(IN),   int'(ein));
      if (Up)   log_q.push_back('{cyc, K_UP});
      if (Down) log_q.push_back('{cyc, K_DN});
      if (Load) log_q.push_back('{cyc, K_LD});
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int ts, tr;

  initial begin
    RST = 1'b0; BTN_UP = 0; BTN_DN = 0; BTN_LD = 0;
    SW = 5'd9; High = 0; Low = 0;
    cycles(3);
    chk("rst_up", int'(Up), 0);
    chk("rst_down", int'(Down), 0);
    chk("rst_load", int'(Load), 0);
    chk("rst_in", int'(IN), 0);
    BTN_LD = 1; cycles(8); BTN_LD = 0; cycles(2);
    RST = 1'b1; cycles(10);
    check_log("reset_ld");

    // load: single pulse at the 7th sampling edge, IN latched
    SW = 5'd26; BTN_LD = 1; ts = cyc + 1;
    cycles(20); BTN_LD = 0; cycles(12);
    want(ts + 6, K_LD);
    check_log("load");
    chk("in_after_load", int'(IN), 26);
    SW = 5'd3; cycles(5);
    chk("in_hold", int'(IN), 26);

    // bounce: 2 high, 1 low, 3 high, 1 low, then steady
    BTN_UP = 1; cycles(2); BTN_UP = 0; cycles(1);
    BTN_UP = 1; cycles(3); BTN_UP = 0; cycles(1);
    BTN_UP = 1; ts = cyc + 1;
    cycles(12); BTN_UP = 0; cycles(12);
    want(ts + 6, K_UP);
    check_log("bounce");

    // down auto-repeat: t0, +16, +24, +32, +40, +48
    BTN_DN = 1; ts = cyc + 1;
    cycles(54); BTN_DN = 0; cycles(12);
    want(ts + 6, K_DN);  want(ts + 22, K_DN); want(ts + 30, K_DN);
    want(ts + 38, K_DN); want(ts + 46, K_DN); want(ts + 54, K_DN);
    check_log("repeat");

    // Low asserted from t0+20 suppresses later repeats
    BTN_DN = 1; ts = cyc + 1;
    cycles(26); Low = 1; cycles(28); BTN_DN = 0; cycles(12); Low = 0;
    want(ts + 6, K_DN); want(ts + 22, K_DN);
    check_log("low_gate");

    // simultaneous press: Load wins; first repeat issues Down only
    SW = 5'd17; BTN_LD = 1; BTN_DN = 1; BTN_UP = 1; ts = cyc + 1;
    cycles(10); BTN_LD = 0; cycles(10); BTN_DN = 0; BTN_UP = 0; cycles(12);
    want(ts + 6, K_LD); want(ts + 22, K_DN);
    check_log("priority");
    chk("in_priority", int'(IN), 17);

    // High blocks the press pulse; repeat slot issues Up once High drops
    High = 1; BTN_UP = 1; ts = cyc + 1;
    cycles(10); High = 0; cycles(14); BTN_UP = 0; cycles(12);
    want(ts + 22, K_UP);
    check_log("high_gate");

    // reset while held: fresh press latency after RST rises
    BTN_UP = 1; ts = cyc + 1;
    cycles(10); RST = 0; cycles(2); RST = 1; tr = cyc + 1;
    cycles(12); BTN_UP = 0; cycles(12);
    want(ts + 6, K_UP); want(tr + 6, K_UP);
    check_log("reset_hold");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
